param_synch_counter: RTL and testbench
======================================

PARAM_SYNCH_COUNTER -- requirements
Module: param_synch_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits (legal range 2..16).
REQ-002 Parameter MODULUS, default 16, SHALL set the count range 0..MODULUS-1 (legal range 2..2^WIDTH).
REQ-003 Parameter PRESCALE, default 4, SHALL set the prescale ratio when the prescaler is compiled in (legal range 2..256).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port clear, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-006 Port count, input, 1 bit, SHALL be the count enable.
REQ-007 Port up, input, 1 bit, SHALL select direction: 1 = increment, 0 = decrement.
REQ-008 Port sclr, input, 1 bit, SHALL be a synchronous clear, active-high.
REQ-009 Port load, input, 1 bit, SHALL request a synchronous parallel load.
REQ-010 Port din, input, WIDTH bits, SHALL be the parallel load value.
REQ-011 Port q, output, WIDTH bits, SHALL be the registered count value.
REQ-012 Port tc, output, 1 bit, SHALL be the combinational terminal-count (carry/borrow) indication for cascading.
REQ-013 Port wrap, output, 1 bit, SHALL be a registered one-cycle pulse marking that a wrap occurred.

Function
REQ-014 Per-edge priority SHALL be: sclr, then load, then count; lower-priority requests in the same cycle SHALL be ignored.
REQ-015 sclr=1 SHALL set q to 0 on the next edge, regardless of up, load and count.
REQ-016 load=1 with sclr=0 SHALL set q to din on the next edge; a din value >= MODULUS SHALL load MODULUS-1 instead.
REQ-017 An advance SHALL occur on an edge where count=1, sclr=0, load=0, and the prescaler permits it (REQ-026).
REQ-018 Advancing with up=1 SHALL give q+1, except that q=MODULUS-1 SHALL wrap to 0.
REQ-019 Advancing with up=0 SHALL give q-1, except that q=0 SHALL wrap to MODULUS-1.
REQ-020 tc SHALL be 1 exactly when the current cycle would produce a wrap advance (up=1 at MODULUS-1, or up=0 at 0), and 0 otherwise.
REQ-021 wrap SHALL be 1 for exactly the one cycle following an edge on which a wrap advance occurred.
REQ-022 Neither load nor sclr SHALL ever assert wrap.
REQ-023 Changing up between cycles SHALL take effect on the next advance, with no lost or extra step.
REQ-024 With count=0, q SHALL hold its value and tc SHALL be 0.

Reset
REQ-025 clear=0 SHALL immediately force q=0, wrap=0 and the prescaler count to 0, independent of clk; the block SHALL resume normal operation on the first rising clk edge after clear returns to 1.

Configuration
REQ-026 With the macro PARAM_SYNCH_COUNTER_PRESCALE_EN defined, an internal modulo-PRESCALE prescaler SHALL increment on each cycle where count=1, sclr=0 and load=0; an advance (and tc) SHALL be permitted only on the cycle where the prescaler equals PRESCALE-1, after which the prescaler returns to 0.
REQ-027 With the macro defined, sclr and load SHALL also reset the prescaler to 0, and the prescaler SHALL hold while count=0.
REQ-028 Without the macro, no prescaler logic SHALL exist, every qualifying count=1 cycle SHALL advance, and the PRESCALE parameter SHALL be ignored.

Verification (WIDTH=4, MODULUS=10, macro undefined unless stated)
REQ-029 Hold clear=0, then release with count=1, up=1 for 12 cycles -> q steps 0..9, 0, 1; tc=1 while q=9; wrap=1 only in the cycle q=0 after the wrap.
REQ-030 load=1, din=4'd13 -> q=9 next cycle with wrap=0; then up=0, count=1 for 11 cycles -> q steps 8..0, 9, 8; tc=1 while q=0.
REQ-031 In one cycle with sclr=1, load=1, din=5, count=1 -> q=0; in the next cycle with load=1, din=5, count=1 -> q=5, and no advance occurs.
REQ-032 Assert clear=0 mid-cycle while q=7 -> q=0 and wrap=0 before the next clk edge; q holds 0 while clear=0 even with count=1.
REQ-033 Macro defined, PRESCALE=3, count=1, up=1 -> q advances once every 3 cycles; asserting load with din=2 mid-period restarts the 3-cycle period from q=2.
REQ-034 Toggle count in the pattern 1,0,1,1,0 from q=8, up=1 -> q reaches 9 after the first 1, then 0 after the third 1, with tc=1 only in that cycle and wrap=1 in the following cycle.

Source files
------------

// File: rtl/param_synch_counter.sv
// Purpose : modulo-MODULUS up/down counter with sync clear, saturating parallel load,
//           combinational terminal count for cascading and a registered wrap pulse.
// Latency : q and wrap update one clk edge after the request; tc is combinational.
// Backpressure: none; count is a plain enable and the counter never stalls a producer.
//
// Ports:
//   clk   - clock; all state updates on its rising edge
//   clear - asynchronous active-low reset (q, wrap and prescaler to 0)
//   count - count enable
//   up    - direction, 1 = increment, 0 = decrement
//   sclr  - synchronous clear, highest priority
//   load  - synchronous parallel load of din (saturated to MODULUS-1)
//   din   - parallel load value
//   q     - registered count value
//   tc    - terminal count: high when this cycle performs a wrapping advance
//   wrap  - one-cycle pulse after an edge that performed a wrapping advance
//
// Optional feature: define PARAM_SYNCH_COUNTER_PRESCALE_EN to compile in a
// modulo-PRESCALE prescaler that gates advances; otherwise PRESCALE is ignored.
module param_synch_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             count,
   input  logic             up,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   // Elaboration-time guard on the legal parameter ranges.
   if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
       PRESCALE < 2 || PRESCALE > 256) begin : g_bad_cfg
      $error("param_synch_counter: illegal WIDTH/MODULUS/PRESCALE");
   end

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q;
   logic [WIDTH-1:0] din_sat;
   logic             tick;
   logic             adv;
   logic             at_max;
   logic             at_min;

`ifdef PARAM_SYNCH_COUNTER_PRESCALE_EN
   // 8 bits covers PRESCALE-1 up to 255.
   logic [7:0] pre_q, pre_d;

   assign tick = (pre_q == 8'(PRESCALE - 1));

   always_comb begin
      pre_d = pre_q;
      if (sclr || load) begin
         pre_d = '0;
      end else if (count) begin
         pre_d = tick ? 8'd0 : pre_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Compare one bit wider so MODULUS == 2**WIDTH is representable.
   assign din_sat = ({1'b0, din} >= (WIDTH + 1)'(MODULUS)) ? MAX_CNT : din;

   assign adv    = count && !sclr && !load && tick;
   assign at_max = (count_q == MAX_CNT);
   assign at_min = (count_q == '0);

   // tc only flags a wrap that will really happen this cycle, so it is
   // suppressed by sclr/load, by count=0 and by an unexpired prescaler.
   assign tc = adv && (up ? at_max : at_min);

   always_comb begin
      count_d = count_q;
      if (sclr) begin
         count_d = '0;
      end else if (load) begin
         count_d = din_sat;
      end else if (adv) begin
         if (up) begin
            count_d = at_max ? '0 : count_q + 1'b1;
         end else begin
            count_d = at_min ? MAX_CNT : count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= tc;
      end
   end

   assign q    = count_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_param_synch_counter.sv
module tb_param_synch_counter;

   localparam int W   = 4;
   localparam int MOD = 10;
   localparam int PS  = 3;

   logic         clk = 1'b0;
   logic         clear;
   logic         count;
   logic         up;
   logic         sclr;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] q;
   logic         tc;
   logic         wrap;

   int checks = 0;
   int passes = 0;

   // Reference model state: plain integers driven by the rules of the counter.
   int m_q    = 0;
   int m_pre  = 0;
   int m_wrap = 0;

   always #5 clk = ~clk;

   param_synch_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(PS)) dut (
      .clk  (clk),
      .clear(clear),
      .count(count),
      .up   (up),
      .sclr (sclr),
      .load (load),
      .din  (din),
      .q    (q),
      .tc   (tc),
      .wrap (wrap)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int prescale_ok();
`ifdef PARAM_SYNCH_COUNTER_PRESCALE_EN
      return (m_pre == PS - 1) ? 1 : 0;
`else
      return 1;
`endif
   endfunction

   // Would this cycle's inputs cause a wrapping advance?
   function automatic int model_tc();
      if (!count || sclr || load || prescale_ok() == 0) return 0;
      if (up) return (m_q == MOD - 1) ? 1 : 0;
      return (m_q == 0) ? 1 : 0;
   endfunction

   // Apply one clock edge worth of behaviour to the model.
   task automatic model_edge();
      int t;
      t = model_tc();
      if (sclr) begin
         m_q   = 0;
         m_pre = 0;
      end else if (load) begin
         m_q   = (int'(din) >= MOD) ? MOD - 1 : int'(din);
         m_pre = 0;
      end else if (count) begin
         if (prescale_ok() != 0)
            m_q = up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
         m_pre = (m_pre + 1) % PS;
      end
      m_wrap = t;
   endtask

   task automatic step(input logic c, input logic u, input logic s, input logic l,
                       input logic [W-1:0] d, input string tag);
      @(negedge clk);
      count = c; up = u; sclr = s; load = l; din = d;
      #1;
      chk({tag, ".tc"}, 32'(tc), 32'(model_tc()));
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, ".q"}, 32'(q), 32'(m_q));
      chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
   endtask

   initial begin
      clear = 1'b0; count = 1'b0; up = 1'b1; sclr = 1'b0; load = 1'b0; din = '0;
      #3;
      chk("reset.q", 32'(q), 32'd0);
      chk("reset.wrap", 32'(wrap), 32'd0);
      @(negedge clk);
      clear = 1'b1;

      // Count up through the wrap: 0..9,0,1.
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "up_run");
      chk("up_run.final", 32'(q), 32'd2);

      // Saturating load then count down through the borrow.
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, "load_sat");
      chk("load_sat.val", 32'(q), 32'd9);
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "down_run");

      // Priority: sclr beats load beats count.
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, "prio_sclr");
      chk("prio_sclr.val", 32'(q), 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, "prio_load");
      chk("prio_load.val", 32'(q), 32'd5);

      // Hold with count=0.
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "hold");

      // Asynchronous clear mid-cycle from q=7.
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, "load7");
      @(negedge clk);
      count = 1'b1; up = 1'b1; load = 1'b0;
      #2 clear = 1'b0;
      #1;
      chk("aclr.q", 32'(q), 32'd0);
      chk("aclr.wrap", 32'(wrap), 32'd0);
      m_q = 0; m_pre = 0; m_wrap = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("aclr.hold", 32'(q), 32'd0);
      @(negedge clk);
      clear = 1'b1;
      count = 1'b0;

      // Count pattern 1,0,1,1,0 from q=8 going up.
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, "pat_load");
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "pat1");
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "pat2");
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "pat3");
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "pat4");
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "pat5");

      // Direction changes between advances.
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "dir_a");
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "dir_b");
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "dir_c");

`ifdef PARAM_SYNCH_COUNTER_PRESCALE_EN
      // Prescaled advance, then a load mid-period restarts the period.
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, "ps_clr");
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "ps_run");
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, "ps_load");
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "ps_run2");
`endif

      // Randomized traffic with rare sclr/load and full-range din.
      for (int i = 0; i < 300; i++) begin
         logic c, u, s, l;
         logic [W-1:0] d;
         c = ($urandom_range(0, 3) != 0);
         u = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 11) == 0);
         d = W'($urandom_range(0, 15));
         step(c, u, s, l, d, "rand");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
